// File: rtl/connect_pkg.sv
// Shared widths, flit/credit field offsets and lock-state encoding for the PE flit/credit link.
package connect_pkg;

  typedef enum logic {
    LockUnlocked = 1'b0,
    LockLocked   = 1'b1
  } lock_state_e;

  function automatic int unsigned vc_bits(input int unsigned num_vcs);
    return (num_vcs > 1) ? $clog2(num_vcs) : 1;
  endfunction

  function automatic int unsigned dest_bits(input int unsigned num_ports);
    return $clog2(num_ports);
  endfunction

  function automatic int unsigned flit_width(input int unsigned data_w,
                                             input int unsigned num_ports,
                                             input int unsigned num_vcs);
    return 2 + data_w + dest_bits(num_ports) + vc_bits(num_vcs);
  endfunction

  function automatic int unsigned credit_width(input int unsigned num_vcs);
    return 1 + vc_bits(num_vcs);
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Flit layout, LSB first: data | vc | dest | tail | valid
  function automatic int unsigned flit_vc_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned flit_dest_lsb(input int unsigned data_w,
                                                input int unsigned num_vcs);
    return data_w + vc_bits(num_vcs);
  endfunction

  function automatic int unsigned flit_tail_bit(input int unsigned data_w,
                                                input int unsigned num_ports,
                                                input int unsigned num_vcs);
    return data_w + vc_bits(num_vcs) + dest_bits(num_ports);
  endfunction

  function automatic int unsigned flit_valid_bit(input int unsigned data_w,
                                                 input int unsigned num_ports,
                                                 input int unsigned num_vcs);
    return flit_tail_bit(data_w, num_ports, num_vcs) + 1;
  endfunction

  // Credit layout: {valid, vc}
  localparam int unsigned CreditVcLsb = 0;

  function automatic int unsigned credit_valid_bit(input int unsigned num_vcs);
    return vc_bits(num_vcs);
  endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-clock per-VC flit FIFO with synchronous reset and fall-through head.
module noc_vc_fifo #(
  parameter int unsigned Width = 39,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (32'(cnt_q) == Depth);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_next(wr_q);
      if (do_pop)  rd_q <= ptr_next(rd_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/noc_credit_sink.sv
// Router-side sink of the PE flit/credit link: per-VC buffering, packet-locked
// round-robin output arbitration and one returned credit per dequeued flit.
module noc_credit_sink
  import connect_pkg::*;
#(
  parameter int unsigned NUM_VCS             = 2,
  parameter int unsigned FLIT_DATA_WIDTH     = 32,
  parameter int unsigned FLIT_BUFFER_DEPTH   = 8,
  parameter int unsigned NUM_USER_RECV_PORTS = 16,
  localparam int unsigned VB = vc_bits(NUM_VCS),
  localparam int unsigned FW = flit_width(FLIT_DATA_WIDTH, NUM_USER_RECV_PORTS, NUM_VCS),
  localparam int unsigned CW = credit_width(NUM_VCS),
  localparam int unsigned OW = occ_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [FW-1:0]         flit_in,
  output logic [CW-1:0]         credit_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FW-1:0]         out_flit,
  output logic [NUM_VCS*OW-1:0] occupancy,
  output logic                  overflow_err
);

  localparam int unsigned VcLsb    = flit_vc_lsb(FLIT_DATA_WIDTH);
  localparam int unsigned TailBit  = flit_tail_bit(FLIT_DATA_WIDTH, NUM_USER_RECV_PORTS, NUM_VCS);
  localparam int unsigned ValidBit = flit_valid_bit(FLIT_DATA_WIDTH, NUM_USER_RECV_PORTS, NUM_VCS);

  logic [NUM_VCS-1:0] push, pop, full, empty;
  logic [FW-1:0]      head  [NUM_VCS];
  logic [OW-1:0]      count [NUM_VCS];

  logic          in_valid, vc_ok, drop, fire;
  logic [VB-1:0] in_vc;
  logic [VB-1:0] grant, cand;
  logic          grant_ok;

  lock_state_e   lock_q, lock_d;
  logic [VB-1:0] lock_vc_q, lock_vc_d;
  logic [VB-1:0] rr_q, rr_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          overflow_q, overflow_d;

  assign in_valid = flit_in[ValidBit];
  assign in_vc    = flit_in[VcLsb +: VB];
  assign vc_ok    = 32'(in_vc) < NUM_VCS;
  // Fullness is the pre-edge state, so a same-cycle pop never rescues a push.
  assign drop     = en && in_valid && (!vc_ok || full[in_vc]);

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign push[v] = en && in_valid && vc_ok && (32'(in_vc) == v) && !full[v];
    assign pop[v]  = fire && (32'(grant) == v);

    noc_vc_fifo #(
      .Width(FW),
      .Depth(FLIT_BUFFER_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[v]),
      .pop  (pop[v]),
      .din  (flit_in),
      .head (head[v]),
      .full (full[v]),
      .empty(empty[v]),
      .count(count[v])
    );

    assign occupancy[v*OW +: OW] = count[v];
  end

  // Downward scan so the lowest offset from the RR pointer wins.
  always_comb begin
    grant    = lock_vc_q;
    grant_ok = 1'b1;
    cand     = '0;
    if (lock_q == LockUnlocked) begin
      grant    = rr_q;
      grant_ok = 1'b0;
      for (int k = NUM_VCS - 1; k >= 0; k--) begin
        cand = VB'((32'(rr_q) + 32'(k)) % NUM_VCS);
        if (!empty[cand]) begin
          grant    = cand;
          grant_ok = 1'b1;
        end
      end
    end
  end

  assign out_valid = en && grant_ok && !empty[grant];
  assign fire      = out_valid && out_ready;

  always_comb begin
    out_flit           = head[grant];
    out_flit[ValidBit] = 1'b1;
  end

  always_comb begin
    lock_d     = lock_q;
    lock_vc_d  = lock_vc_q;
    rr_d       = rr_q;
    credit_d   = '0;
    overflow_d = overflow_q || drop;
    if (fire) begin
      credit_d = {1'b1, grant};
      if (head[grant][TailBit]) begin
        lock_d = LockUnlocked;
        rr_d   = (32'(grant) == NUM_VCS - 1) ? '0 : grant + VB'(1);
      end else begin
        lock_d    = LockLocked;
        lock_vc_d = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= LockUnlocked;
      lock_vc_q  <= '0;
      rr_q       <= '0;
      credit_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_vc_q  <= lock_vc_d;
      rr_q       <= rr_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  assign credit_out   = credit_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_noc_credit_sink.sv
// Randomised and directed bench for noc_credit_sink against a queue-based link model.
module tb_noc_credit_sink;

  localparam int unsigned NV     = 2;
  localparam int unsigned DW     = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned NP     = 16;
  localparam int unsigned VB     = 1;
  localparam int unsigned DB     = 4;
  localparam int unsigned FW     = 2 + DW + DB + VB;
  localparam int unsigned CW     = 1 + VB;
  localparam int unsigned OW     = 4;
  localparam int unsigned VALIDB = FW - 1;
  localparam int unsigned TAILB  = FW - 2;
  localparam int unsigned VCL    = DW;

  logic             clk = 1'b0;
  logic             rst, en, out_ready, out_valid, overflow_err;
  logic [FW-1:0]    flit_in, out_flit;
  logic [CW-1:0]    credit_out;
  logic [NV*OW-1:0] occupancy;

  always #5 clk = ~clk;

  noc_credit_sink #(
    .NUM_VCS            (NV),
    .FLIT_DATA_WIDTH    (DW),
    .FLIT_BUFFER_DEPTH  (DEPTH),
    .NUM_USER_RECV_PORTS(NP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .flit_in     (flit_in),
    .credit_out  (credit_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_flit    (out_flit),
    .occupancy   (occupancy),
    .overflow_err(overflow_err)
  );

  // Link model: one queue of buffered flits per VC plus arbitration state.
  logic [FW-1:0] mq [NV][$];
  bit            m_locked;
  int unsigned   m_lock_vc, m_rr;
  logic [CW-1:0] m_credit;
  bit            m_ovf;
  bit            armed = 1'b0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_grant(output bit vld, output int unsigned g);
    vld = 1'b0;
    g   = m_lock_vc;
    if (m_locked) begin
      vld = mq[g].size() > 0;
    end else begin
      for (int k = 0; k < NV; k++) begin
        int unsigned v = (m_rr + k) % NV;
        if (!vld && mq[v].size() > 0) begin
          vld = 1'b1;
          g   = v;
        end
      end
    end
    vld = vld && en;
  endfunction

  function automatic logic [FW-1:0] mk(input bit tail, input int unsigned vc,
                                       input logic [DW-1:0] d, input logic [DB-1:0] dest);
    return {1'b1, tail, dest, VB'(vc), d};
  endfunction

  task automatic step(input logic e, input logic [FW-1:0] f, input logic r);
    en        = e;
    flit_in   = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Model update on each rising edge using the pre-edge inputs.
  initial begin
    bit            vld;
    int unsigned   g, vc;
    logic [FW-1:0] f;
    int unsigned   pre_sz [NV];
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int v = 0; v < NV; v++) mq[v].delete();
        m_locked  = 1'b0;
        m_lock_vc = 0;
        m_rr      = 0;
        m_credit  = '0;
        m_ovf     = 1'b0;
        armed     = 1'b1;
      end else if (en) begin
        for (int v = 0; v < NV; v++) pre_sz[v] = mq[v].size();
        model_grant(vld, g);
        m_credit = '0;
        if (vld && out_ready) begin
          f        = mq[g].pop_front();
          m_credit = {1'b1, VB'(g)};
          if (f[TAILB]) begin
            m_locked = 1'b0;
            m_rr     = (g + 1) % NV;
          end else begin
            m_locked  = 1'b1;
            m_lock_vc = g;
          end
        end
        if (flit_in[VALIDB]) begin
          vc = 32'(flit_in[VCL +: VB]);
          if (vc >= NV || pre_sz[vc] >= DEPTH) m_ovf = 1'b1;
          else mq[vc].push_back(flit_in);
        end
      end else begin
        m_credit = '0;
      end
    end
  end

  // Monitor: compare every visible output on the falling edge.
  initial begin
    bit            vld;
    int unsigned   g;
    logic [FW-1:0] f;
    forever begin
      @(negedge clk);
      if (armed) begin
        model_grant(vld, g);
        chk("out_valid", 64'(out_valid), 64'(vld));
        if (vld && out_valid) begin
          f         = mq[g][0];
          f[VALIDB] = 1'b1;
          chk("out_flit", 64'(out_flit), 64'(f));
        end
        chk("credit_out", 64'(credit_out), 64'(m_credit));
        for (int v = 0; v < NV; v++)
          chk("occupancy", 64'(occupancy[v*OW +: OW]), 64'(mq[v].size()));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      end
    end
  end

  initial begin
    logic          e, r;
    logic [FW-1:0] f;
    int unsigned   ready_pct;
    rst = 1'b1; en = 1'b0; flit_in = '0; out_ready = 1'b0;
    step(0, '0, 0);
    step(0, '0, 0);
    rst = 1'b0;

    // Three flits on VC1 drained in order.
    step(1, mk(0, 1, 32'hA, 4'h1), 1);
    step(1, mk(0, 1, 32'hB, 4'h1), 1);
    step(1, mk(1, 1, 32'hC, 4'h1), 1);
    repeat (4) step(1, '0, 1);

    // Fill VC0, then one more push is dropped.
    for (int i = 0; i < 8; i++) step(1, mk(1, 0, 32'(16 + i), 4'h2), 0);
    step(1, mk(1, 0, 32'hDEAD, 4'h2), 0);
    step(1, '0, 0);
    @(negedge clk);
    chk("overflow_set", 64'(overflow_err), 64'd1);
    chk("vc0_full_occ", 64'(occupancy[OW-1:0]), 64'd8);
    repeat (10) step(1, '0, 1);

    rst = 1'b1;
    step(1, '0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("overflow_cleared", 64'(overflow_err), 64'd0);

    // Multi-flit packet on VC0 must not interleave with VC1.
    step(1, mk(0, 0, 32'h1, 4'h3), 0);
    step(1, mk(0, 0, 32'h2, 4'h3), 0);
    step(1, mk(1, 0, 32'h3, 4'h3), 0);
    step(1, mk(1, 1, 32'h4, 4'h3), 0);
    repeat (6) step(1, '0, 1);

    // Locked on VC0 with an empty FIFO: VC1 must wait.
    step(1, mk(0, 0, 32'h10, 4'h4), 0);
    step(1, mk(1, 1, 32'h11, 4'h4), 0);
    step(1, '0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lock_hold", 64'(out_valid), 64'd0);
      step(1, '0, 1);
    end
    step(1, mk(1, 0, 32'h12, 4'h4), 1);
    repeat (4) step(1, '0, 1);

    // Enable low freezes everything.
    step(1, mk(1, 1, 32'h20, 4'h5), 0);
    step(1, mk(1, 0, 32'h21, 4'h5), 0);
    repeat (4) step(0, mk(1, 0, 32'h22, 4'h5), 1);
    repeat (4) step(1, '0, 1);

    // Reset with five flits buffered.
    for (int i = 0; i < 5; i++) step(1, mk(1, i % 2, 32'(48 + i), 4'h6), 0);
    rst = 1'b1;
    step(1, '0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_credit", 64'(credit_out), 64'd0);

    // Random traffic with alternating drain pressure.
    for (int i = 0; i < 3000; i++) begin
      ready_pct = ((i / 500) % 2 == 1) ? 40 : 85;
      rst = ($urandom_range(0, 499) == 0);
      e   = ($urandom_range(0, 9) != 0);
      r   = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 9) < 6)
        f = mk($urandom_range(0, 9) < 3, $urandom_range(0, NV - 1), $urandom,
               4'($urandom_range(0, 15)));
      else
        f = '0;
      step(e, f, r);
    end
    rst = 1'b0;
    repeat (3) step(1, '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
